mul8_prod_acc: RTL and testbench

Streaming accumulator that sits directly downstream of the 8x8 approximate multiplier. It consumes its 16-bit unsigned product and sums a programmable-length frame of products into one wide result. The result is handed off over a valid/ready handshake. It provides the registered, back-pressurable boundary the purely combinational multiplier lacks, for dot-product and error-statistics experiments.

---
 rtl/mul8_acc_pkg.sv | 23 ++
 rtl/mul8_acc_add.sv | 38 +++
 rtl/mul8_prod_acc.sv | 163 ++++++++++++++++
 tb/tb_mul8_prod_acc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul8_acc_pkg
// Description : Shared types and constants for the mul8 product accumulator.
//               - state_e   : accumulator control states (ACCUM, HOLD)
//               - PROD_W    : width of the multiplier product feeding the block
//               - ACC_W_MIN / ACC_W_MAX : legal accumulator width bounds,
//                 checked at elaboration time by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package mul8_acc_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_MIN = 17;
  localparam int ACC_W_MAX = 32;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mul8_acc_add.sv
`default_nettype none
// ============================================================================
// Module      : mul8_acc_add
// Description : Combinational ACC_W-bit adder: acc + zero-extended product.
//               Configuration macro ACC_SAT_EN: when defined, a carry-out
//               clamps the sum to all-ones; otherwise the sum wraps.
// Ports       : acc_i   [ACC_W]  current accumulator value
//               prod_i  [PROD_W] unsigned product to add
//               sum_o   [ACC_W]  new accumulator value (wrapped or clamped)
//               carry_o [1]      carry-out of the ACC_W+1-bit addition
// Revision    : 1.0 - initial release
// ============================================================================
module mul8_acc_add
  import mul8_acc_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] w_raw;

  assign w_raw   = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign carry_o = w_raw[ACC_W];

`ifdef ACC_SAT_EN
  // Once clamped at all-ones, any further non-zero product carries again,
  // so the accumulator stays pinned for the rest of the frame.
  assign sum_o = w_raw[ACC_W] ? {ACC_W{1'b1}} : w_raw[ACC_W-1:0];
`else
  assign sum_o = w_raw[ACC_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/mul8_prod_acc.sv
`default_nettype none
// ============================================================================
// Module      : mul8_prod_acc
// Description : Streaming frame accumulator behind the 8x8 approximate
//               multiplier. Sums cfg_len+1 products (or fewer on flush) and
//               hands the result off over a valid/ready handshake.
//               Configuration macro ACC_SAT_EN selects saturating (defined)
//               or wrapping (undefined) accumulation; see mul8_acc_add.
// Ports       : clk          sole clock, rising edge
//               rst_n        synchronous active-low reset
//               cfg_len_i    frame length minus one (latched on first beat)
//               in_valid_i   product valid
//               in_ready_o   block accepts a product this cycle
//               in_prod_i    16-bit unsigned product
//               flush_i      close the current frame early
//               out_valid_o  result valid
//               out_ready_i  consumer accepts result
//               out_sum_o    frame sum
//               out_count_o  number of products in the frame
//               out_ovf_o    a carry-out occurred during the frame
// Revision    : 1.0 - initial release
// ============================================================================
module mul8_prod_acc
  import mul8_acc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PROD_W-1:0] in_prod_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  out_sum_o,
  output logic [LEN_W:0]    out_count_o,
  output logic              out_ovf_o
);

  generate
    if (ACC_W < ACC_W_MIN || ACC_W > ACC_W_MAX) begin : g_acc_w_bad
      $error("mul8_prod_acc: ACC_W outside legal range");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [LEN_W:0]    cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic [ACC_W-1:0]  out_sum_q;
  logic [LEN_W:0]    out_count_q;
  logic              out_ovf_q;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic              w_in_ready;
  logic              w_beat;
  logic              w_first;
  logic [LEN_W-1:0]  w_len;
  logic              w_last;
  logic              w_close;
  logic [ACC_W-1:0]  w_add_sum;
  logic              w_add_carry;
  logic [ACC_W-1:0]  sum_d;
  logic [LEN_W:0]    count_d;
  logic              ovf_d;

  mul8_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .prod_i  (in_prod_i),
    .sum_o   (w_add_sum),
    .carry_o (w_add_carry)
  );

  // Gated by rst_n so the port reads 0 throughout reset and 1 as soon as
  // reset is released; out_ready_i never feeds this path.
  assign w_in_ready = rst_n & (state_q == ACCUM);
  assign w_beat     = in_valid_i & w_in_ready;
  assign w_first    = (cnt_q == '0);

  // On the first beat the live cfg_len_i is the frame length; afterwards
  // the latched copy is used so mid-frame changes have no effect.
  assign w_len      = w_first ? cfg_len_i : len_q;
  assign w_last     = w_beat & (cnt_q == {1'b0, w_len});

  // A flush closes only if the frame holds at least one product,
  // counting a beat arriving in the same cycle.
  assign w_close    = w_last |
                      ((state_q == ACCUM) & flush_i & (w_beat | ~w_first));

  assign sum_d      = w_beat ? w_add_sum : acc_q;
  assign count_d    = w_beat ? (cnt_q + 1'b1) : cnt_q;
  assign ovf_d      = ovf_q | (w_beat & w_add_carry);

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (w_close) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_d;
            out_count_q <= count_d;
            out_ovf_q   <= ovf_d;
            state_q     <= HOLD;
          end else if (w_beat) begin
            acc_q <= w_add_sum;
            cnt_q <= count_d;
            ovf_q <= ovf_d;
            if (w_first) begin
              len_q <= cfg_len_i;
            end
          end
        end
        HOLD: begin
          // Result registers keep their value after the handshake; only
          // out_valid drops. The working accumulator restarts from zero.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_count_o = out_count_q;
  assign out_ovf_o   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mul8_prod_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul8_prod_acc
// Description : Self-checking bench for mul8_prod_acc (ACC_W=17 so that
//               overflow is reachable with short frames). Expected results
//               come from the arithmetic total of each frame's products,
//               folded by wrap or clamp depending on ACC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul8_prod_acc;

  localparam int    ACC_W = 17;
  localparam int    LEN_W = 8;
  localparam longint MAXV = (64'sd1 <<< ACC_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [LEN_W-1:0]  cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_prod;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [LEN_W:0]    out_count;
  logic              out_ovf;

  int     n_checks;
  int     n_fail;
  longint frame_total;
  int     frame_cnt;

  mul8_prod_acc #(
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_len_i   (cfg_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_prod_i   (in_prod),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_count_o (out_count),
    .out_ovf_o   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: a frame's arithmetic total, folded to ACC_W bits.
  function automatic longint ref_sum(input longint total);
`ifdef ACC_SAT_EN
    return (total > MAXV) ? MAXV : total;
`else
    return total % (MAXV + 1);
`endif
  endfunction

  function automatic logic ref_ovf(input longint total);
    return (total > MAXV);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted product; afterwards out_valid must equal 'last'.
  task automatic send(input int p, input logic last, input logic fl);
    in_valid = 1'b1;
    in_prod  = 16'(p);
    flush    = fl;
    check("in_ready_at_beat", {63'd0, in_ready}, 64'd1);
    frame_total += longint'(p);
    frame_cnt++;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("out_valid_after_beat", {63'd0, out_valid}, {63'd0, last});
  endtask

  task automatic expect_frame(input int stall);
    longint es;
    logic   eo;
    es = ref_sum(frame_total);
    eo = ref_ovf(frame_total);
    check("out_valid", {63'd0, out_valid}, 64'd1);
    check("out_sum", 64'(out_sum), 64'(es));
    check("out_count", 64'(out_count), 64'(frame_cnt));
    check("out_ovf", {63'd0, out_ovf}, {63'd0, eo});
    check("in_ready_hold", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < stall; i++) begin
      flush = 1'b1;  // ignored while holding
      tick();
      flush = 1'b0;
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_sum", 64'(out_sum), 64'(es));
      check("stall_count", 64'(out_count), 64'(frame_cnt));
      check("stall_ovf", {63'd0, out_ovf}, {63'd0, eo});
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_after_accept", {63'd0, out_valid}, 64'd0);
    check("in_ready_after_accept", {63'd0, in_ready}, 64'd1);
    frame_total = 0;
    frame_cnt   = 0;
  endtask

  initial begin
    int len;
    n_checks    = 0;
    n_fail      = 0;
    frame_total = 0;
    frame_cnt   = 0;
    rst_n       = 1'b0;
    cfg_len     = '0;
    in_valid    = 1'b0;
    in_prod     = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_release", {63'd0, in_ready}, 64'd1);

    // Basic frame with 5-cycle backpressure
    cfg_len = 8'd3;
    send(100, 1'b0, 1'b0);
    send(200, 1'b0, 1'b0);
    send(300, 1'b0, 1'b0);
    send(400, 1'b1, 1'b0);
    check("basic_sum_const", 64'(out_sum), 64'd1000);
    expect_frame(5);

    // Overflow: three 0xFFFF products
    cfg_len = 8'd2;
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'hFFFF, 1'b1, 1'b0);
`ifdef ACC_SAT_EN
    check("ovf_sum_const", 64'(out_sum), 64'h1FFFF);
`else
    check("ovf_sum_const", 64'(out_sum), 64'h0FFFD);
`endif
    expect_frame(1);

    // Flush together with a beat
    cfg_len = 8'd7;
    send(5, 1'b0, 1'b0);
    send(6, 1'b0, 1'b0);
    send(7, 1'b1, 1'b1);
    check("flush_beat_sum", 64'(out_sum), 64'd18);
    check("flush_beat_count", 64'(out_count), 64'd3);
    expect_frame(0);

    // Flush without a beat
    send(5, 1'b0, 1'b0);
    send(6, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_only_count", 64'(out_count), 64'd2);
    expect_frame(2);

    // Flush coinciding with the natural last beat: one frame only
    cfg_len = 8'd1;
    send(1, 1'b0, 1'b0);
    send(2, 1'b1, 1'b1);
    expect_frame(0);
    tick();
    check("no_extra_frame", {63'd0, out_valid}, 64'd0);

    // Flush while idle produces nothing
    for (int i = 0; i < 3; i++) begin
      flush = 1'b1;
      tick();
      check("idle_flush_valid", {63'd0, out_valid}, 64'd0);
    end
    flush = 1'b0;

    // Mid-frame length change is ignored
    cfg_len = 8'd1;
    send(10, 1'b0, 1'b0);
    cfg_len = 8'd5;
    send(20, 1'b1, 1'b0);
    check("midcfg_count", 64'(out_count), 64'd2);
    expect_frame(0);

    // Reset mid-frame
    cfg_len = 8'd7;
    send(1, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_sum", 64'(out_sum), 64'd0);
    check("midrst_count", 64'(out_count), 64'd0);
    check("midrst_ovf", {63'd0, out_ovf}, 64'd0);
    rst_n = 1'b1;
    #1;
    frame_total = 0;
    frame_cnt   = 0;
    check("midrst_release_ready", {63'd0, in_ready}, 64'd1);
    cfg_len = 8'd1;
    send(10, 1'b0, 1'b0);
    send(20, 1'b1, 1'b0);
    check("post_rst_sum", 64'(out_sum), 64'd30);
    expect_frame(0);

    // Randomized frames with input gaps and output stalls
    for (int f = 0; f < 30; f++) begin
      len     = int'($urandom_range(0, 7));
      cfg_len = 8'(len);
      for (int i = 0; i <= len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (i > 0) cfg_len = 8'($urandom_range(0, 255));
        send(int'($urandom_range(0, 65535)), (i == len), 1'b0);
      end
      expect_frame(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
